spi_s_core: RTL and testbench
=============================

# spi_s_core

SPI slave engine that sits directly downstream of the memory-mapped SPI master and consumes its CS, SCK and DOUT pins. It oversamples the SPI pins in the system clock domain and supports all four CPOL/CPHA modes with 8-bit MSB-first frames. It delivers received bytes and accepts reply bytes through valid/ready handshakes, and drives MISO back into the master's DIN. It serves as both the bench-side partner for master regression and the slave core for on-chip SPI targets.

## Interface
- `SYNC_STAGES`, default 2: flops in each pin synchronizer, minimum 2.
- `IDLE_TX`, default 8'hFF: byte shifted out when no TX byte is queued.
- `clock` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `spi_mode` in 2: {CPOL,CPHA}; sampled only while the slave is in IDLE.
- `cs_n` in 1: chip select, active low (the master's CS pin).
- `sck` in 1: serial clock (the master's SCK pin).
- `mosi` in 1: serial data in (the master's DOUT pin).
- `miso` out 1: serial data out (the master's DIN pin).
- `miso_oe` out 1: MISO output enable; high while the frame is selected.
- `rx_data` out 8: received byte.
- `rx_valid` out 1: `rx_data` holds an unconsumed byte.
- `rx_ready` in 1: consumer accepts `rx_data` when `rx_valid && rx_ready`.
- `tx_data` in 8: reply byte.
- `tx_valid` in 1: `tx_data` offered.
- `tx_ready` out 1: the single-entry TX holding register is empty.
- `busy` out 1: state is not IDLE.
- `overrun` out 1: one-cycle pulse when a byte is dropped.
- `underrun` out 1: one-cycle pulse when `IDLE_TX` is loaded.
- `frame_abort` out 1: one-cycle pulse when CS rises mid-byte.

## Operation
- Pin synchronizers: reset values are `cs_n`=1, `sck`=CPOL, `mosi`=0. Edges are detected by comparing the synced value with its one-cycle-delayed copy.
- Leading edge is the first SCK transition away from CPOL. Trailing edge is the return to CPOL.
- Edge roles by CPHA:
  - CPHA=0: sample on leading, shift out on trailing.
  - CPHA=1: shift out on leading, sample on trailing.
- States:
  - IDLE: `miso_oe`=0. A synced `cs_n` fall latches `spi_mode` and goes to LOAD.
  - LOAD (1 cycle): the TX shift register takes the holding register, or `IDLE_TX` with an `underrun` pulse. Bit count is cleared. Then go to SHIFT.
  - SHIFT: `miso` = shift_tx[7]. A sample edge shifts `mosi` into shift_rx at the LSB and increments the bit count. A shift-out edge left-shifts shift_tx.
  - SHIFT byte completion: on the 8th sample edge the byte goes to `rx_data` and the count wraps to 0. shift_tx reloads from the holding register (or `IDLE_TX`) on the next shift-out edge, which allows back-to-back bytes under one CS.
  - Any state: synced `cs_n` rise returns to IDLE. If bit count ≠0 at that point, pulse `frame_abort` and discard the partial byte.
- For CPHA=1, the first leading edge does not shift, because the MSB is already presented from LOAD.
- RX handling:
  - When a byte completes while `rx_valid && !rx_ready`: keep the old byte, drop the new one, pulse `overrun`.
  - When a byte completes in the same cycle as a handshake: load the new byte, and `rx_valid` stays 1.
- TX holding register: written on `tx_valid && tx_ready`. It is freed when loaded into shift_tx.
- Reset clears all registers regardless of pin state. A frame already in progress is then ignored until CS next falls.

## Timing
- Reset values: `miso`=1, `miso_oe`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `busy`=0, `overrun`=0, `underrun`=0, `frame_abort`=0.
- Pin-to-detect latency is SYNC_STAGES+1 cycles. `miso` changes SYNC_STAGES+2 cycles after the SCK pin edge.
- SCK constraints:
  - Each SCK phase must last ≥ SYNC_STAGES+3 clocks.
  - The CS-fall-to-first-SCK-edge gap must be ≥ SYNC_STAGES+3 clocks.
  - With SYNC_STAGES=2 this means a master CLKDIV ≥ 2 on a shared clock.
- `rx_valid` rises SYNC_STAGES+2 cycles after the 8th sample-edge pin transition.
- `tx_ready` rises the cycle after shift_tx loads from the holding register.

## Structure
- Package `spi_pkg`:
  - `spi_mode_t` (MODE0..MODE3) and `spi_state_t` (IDLE, LOAD, SHIFT).
  - `SPI_DATA_W`=8.
  - The same package is also used by the master.
- Sub-module `spi_s_sync`: a SYNC_STAGES synchronizer plus rise/fall edge detect. Instantiate it for `cs_n`, `sck` and `mosi`.
- All remaining logic (FSM, shift registers, holding registers) goes in `spi_s_core`.

## Test plan
- Mode 0, master clkdiv=2, sends 0xC3 with the slave TX queued at 0x3C.
  - `rx_data`=0xC3 with one `rx_valid`.
  - The master reads 0x3C.
- Mode 3, master clkdiv=2, sends 0x00 with the slave TX queued at 0xA5.
  - The master reads 0xA5.
  - `rx_data`=0x00.
- Two bytes (0x12, 0x34) under a single CS, TX queued at 0x56 then 0x78.
  - Two `rx_valid` handshakes.
  - The master reads 0x56, 0x78.
  - `underrun` never fires.
- No TX queued, mode 1:
  - The master reads 0xFF.
  - `underrun` pulses once.
- `rx_ready` held 0 across two bytes (0xAA, 0x55):
  - `rx_data` stays 0xAA.
  - `overrun` pulses once.
- CS rises after 3 bits:
  - `frame_abort` pulses and `rx_valid` stays 0.
  - The next full frame receives 0x81 correctly.
- `reset` asserted mid-frame:
  - All outputs return to reset values.
  - The next frame is clean.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI types and helpers used by both the SPI master and the SPI slave core.
package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_CNT_W  = 3;

  // Index of the last bit in a frame; the bit counter wraps after it.
  localparam logic [SPI_CNT_W-1:0] SPI_BIT_LAST = 3'd7;

  // {CPOL,CPHA}
  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_t;

  // Idle level of SCK for a mode.
  function automatic logic mode_cpol(input spi_mode_t m);
    logic [1:0] b;
    b = m;
    return b[1];
  endfunction

  // Clock phase of a mode: 1 means data is launched on the leading edge.
  function automatic logic mode_cpha(input spi_mode_t m);
    logic [1:0] b;
    b = m;
    return b[0];
  endfunction

endpackage

// File: rtl/spi_s_sync.sv
// Pin synchronizer with a delayed copy and registered rise/fall pulses.
// The level and the edge pulses are aligned: both reflect the pin after
// SYNC_STAGES+1 clock edges.
module spi_s_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic rst_val,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_r;
  logic                   last_r;
  logic                   rise_r;
  logic                   fall_r;

  // Shift the pin through the synchronizer and register edge pulses against the delayed copy
  always_ff @(posedge clock) begin
    if (reset) begin
      chain_r <= {SYNC_STAGES{rst_val}};
      last_r  <= rst_val;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], din};
      last_r  <= chain_r[SYNC_STAGES-1];
      rise_r  <= chain_r[SYNC_STAGES-1] & ~last_r;
      fall_r  <= ~chain_r[SYNC_STAGES-1] & last_r;
    end
  end

  assign level = last_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/spi_s_core.sv
// SPI slave engine: oversamples CS/SCK/MOSI in the system clock domain,
// supports all four CPOL/CPHA modes with 8-bit MSB-first frames, and
// exchanges bytes with the local side through valid/ready handshakes.
module spi_s_core
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_DATA_W-1:0] IDLE_TX     = 8'hFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            spi_mode,
  input  logic                  cs_n,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [SPI_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [SPI_DATA_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  underrun,
  output logic                  frame_abort
);

  // After reset the synchronizers flush from their reset values; a CS fall
  // seen during that window belongs to a frame already in progress and is
  // ignored so the slave waits for the next genuine CS fall.
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 3);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SYNC_STAGES + 2);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);

  logic cs_level_s, cs_rise_s, cs_fall_s;
  logic sck_level_s, sck_rise_s, sck_fall_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;
  logic unused_s;

  spi_state_t state_r, nx_state_s;

  spi_mode_t             mode_r, nx_mode_s;
  logic [SPI_DATA_W-1:0] shift_tx_r, nx_shift_tx_s;
  logic [SPI_DATA_W-1:0] shift_rx_r, nx_shift_rx_s;
  logic [SPI_CNT_W-1:0]  bit_cnt_r, nx_bit_cnt_s;
  logic                  skip_r, nx_skip_s;
  logic                  reload_r, nx_reload_s;
  logic [SPI_DATA_W-1:0] hold_r, nx_hold_s;
  logic                  hold_full_r, nx_hold_full_s;
  logic [SPI_DATA_W-1:0] rx_data_r, nx_rx_data_s;
  logic                  rx_valid_r, nx_rx_valid_s;
  logic                  overrun_r, nx_overrun_s;
  logic                  underrun_r, nx_underrun_s;
  logic                  abort_r, nx_abort_s;
  logic                  miso_r, nx_miso_s;
  logic                  miso_oe_r;
  logic                  busy_r;
  logic                  tx_ready_r;
  logic [SETTLE_W-1:0]   settle_r;
  logic                  settled_s;

  logic                  cpol_s, cpha_s;
  logic                  lead_s, trail_s, sample_s, shout_s;
  logic                  byte_done_s, tx_load_s;
  logic [SPI_DATA_W-1:0] rx_byte_s, tx_word_s;

  spi_s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clock(clock), .reset(reset), .rst_val(1'b1), .din(cs_n),
    .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  spi_s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clock(clock), .reset(reset), .rst_val(spi_mode[1]), .din(sck),
    .level(sck_level_s), .rise(sck_rise_s), .fall(sck_fall_s)
  );

  spi_s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clock(clock), .reset(reset), .rst_val(1'b0), .din(mosi),
    .level(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  // Only edges of CS/SCK and the level of MOSI carry meaning here.
  assign unused_s  = ^{cs_level_s, sck_level_s, mosi_rise_s, mosi_fall_s};
  assign settled_s = (settle_r == SETTLE_LAST);

  // Map raw SCK edges onto leading/trailing and then onto sample/shift-out roles
  always_comb begin
    cpol_s = mode_cpol(mode_r);
    cpha_s = mode_cpha(mode_r);
    if (cpol_s) begin
      lead_s  = sck_fall_s;
      trail_s = sck_rise_s;
    end else begin
      lead_s  = sck_rise_s;
      trail_s = sck_fall_s;
    end
    if (cpha_s) begin
      sample_s = trail_s;
      shout_s  = lead_s;
    end else begin
      sample_s = lead_s;
      shout_s  = trail_s;
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nx_state_s;
    end
  end

  // FSM next state: CS fall starts a frame, CS rise ends it from any state
  always_comb begin
    nx_state_s = state_r;
    if (cs_rise_s) begin
      nx_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (cs_fall_s && settled_s) begin
            nx_state_s = LOAD;
          end else begin
            nx_state_s = IDLE;
          end
        end
        LOAD:    nx_state_s = SHIFT;
        SHIFT:   nx_state_s = SHIFT;
        default: nx_state_s = IDLE;
      endcase
    end
  end

  // Datapath next values: shift registers, bit counter, TX holding register and RX output
  always_comb begin
    nx_mode_s      = mode_r;
    nx_shift_tx_s  = shift_tx_r;
    nx_shift_rx_s  = shift_rx_r;
    nx_bit_cnt_s   = bit_cnt_r;
    nx_skip_s      = skip_r;
    nx_reload_s    = reload_r;
    nx_hold_s      = hold_r;
    nx_hold_full_s = hold_full_r;
    nx_rx_data_s   = rx_data_r;
    nx_rx_valid_s  = rx_valid_r;
    nx_overrun_s   = 1'b0;
    nx_underrun_s  = 1'b0;
    nx_abort_s     = 1'b0;
    nx_miso_s      = 1'b1;
    byte_done_s    = 1'b0;
    tx_load_s      = 1'b0;
    rx_byte_s      = {shift_rx_r[SPI_DATA_W-2:0], mosi_s};
    tx_word_s      = hold_full_r ? hold_r : IDLE_TX;

    if (cs_rise_s) begin
      // Deselect: a partially received byte is thrown away.
      if (bit_cnt_r != 3'd0) begin
        nx_abort_s = 1'b1;
      end else begin
        nx_abort_s = 1'b0;
      end
      nx_bit_cnt_s = 3'd0;
      nx_reload_s  = 1'b0;
      nx_skip_s    = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cs_fall_s && settled_s) begin
            nx_mode_s = spi_mode_t'(spi_mode);
          end else begin
            nx_mode_s = mode_r;
          end
        end
        LOAD: begin
          tx_load_s    = 1'b1;
          nx_bit_cnt_s = 3'd0;
          nx_reload_s  = 1'b0;
          // With CPHA=1 the MSB is already on MISO, so the first leading edge must not shift.
          nx_skip_s    = cpha_s;
        end
        SHIFT: begin
          if (sample_s) begin
            nx_shift_rx_s = rx_byte_s;
            nx_bit_cnt_s  = bit_cnt_r + 3'd1;
            if (bit_cnt_r == SPI_BIT_LAST) begin
              byte_done_s = 1'b1;
              nx_reload_s = 1'b1;
            end else begin
              byte_done_s = 1'b0;
            end
          end else if (shout_s) begin
            if (skip_r) begin
              nx_skip_s = 1'b0;
            end else if (reload_r) begin
              // First shift-out edge after a completed byte presents the next byte's MSB.
              tx_load_s   = 1'b1;
              nx_reload_s = 1'b0;
            end else begin
              nx_shift_tx_s = {shift_tx_r[SPI_DATA_W-2:0], 1'b0};
            end
          end else begin
            nx_shift_rx_s = shift_rx_r;
          end
        end
        default: begin
          nx_bit_cnt_s = 3'd0;
        end
      endcase
    end

    // TX holding register: freed by a load into shift_tx, refilled by the handshake.
    if (tx_load_s) begin
      nx_shift_tx_s  = tx_word_s;
      nx_underrun_s  = ~hold_full_r;
      nx_hold_full_s = 1'b0;
    end else if (tx_valid && tx_ready_r) begin
      nx_hold_s      = tx_data;
      nx_hold_full_s = 1'b1;
    end else begin
      nx_hold_full_s = hold_full_r;
    end

    // RX output: an unconsumed byte is never overwritten.
    if (byte_done_s) begin
      if (!rx_valid_r || rx_ready) begin
        nx_rx_data_s  = rx_byte_s;
        nx_rx_valid_s = 1'b1;
      end else begin
        nx_overrun_s = 1'b1;
      end
    end else if (rx_valid_r && rx_ready) begin
      nx_rx_valid_s = 1'b0;
    end else begin
      nx_rx_valid_s = rx_valid_r;
    end

    // MISO follows the next shift_tx MSB so it moves in the same cycle shift_tx does.
    if (nx_state_s == SHIFT) begin
      nx_miso_s = nx_shift_tx_s[SPI_DATA_W-1];
    end else begin
      nx_miso_s = 1'b1;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_r      <= MODE0;
      shift_tx_r  <= 8'h00;
      shift_rx_r  <= 8'h00;
      bit_cnt_r   <= 3'd0;
      skip_r      <= 1'b0;
      reload_r    <= 1'b0;
      hold_r      <= 8'h00;
      hold_full_r <= 1'b0;
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      overrun_r   <= 1'b0;
      underrun_r  <= 1'b0;
      abort_r     <= 1'b0;
      miso_r      <= 1'b1;
      miso_oe_r   <= 1'b0;
      busy_r      <= 1'b0;
      tx_ready_r  <= 1'b1;
      settle_r    <= '0;
    end else begin
      mode_r      <= nx_mode_s;
      shift_tx_r  <= nx_shift_tx_s;
      shift_rx_r  <= nx_shift_rx_s;
      bit_cnt_r   <= nx_bit_cnt_s;
      skip_r      <= nx_skip_s;
      reload_r    <= nx_reload_s;
      hold_r      <= nx_hold_s;
      hold_full_r <= nx_hold_full_s;
      rx_data_r   <= nx_rx_data_s;
      rx_valid_r  <= nx_rx_valid_s;
      overrun_r   <= nx_overrun_s;
      underrun_r  <= nx_underrun_s;
      abort_r     <= nx_abort_s;
      miso_r      <= nx_miso_s;
      miso_oe_r   <= (nx_state_s != IDLE);
      busy_r      <= (nx_state_s != IDLE);
      tx_ready_r  <= ~nx_hold_full_s;
      if (!settled_s) begin
        settle_r <= settle_r + SETTLE_ONE;
      end else begin
        settle_r <= settle_r;
      end
    end
  end

  assign miso        = miso_r;
  assign miso_oe     = miso_oe_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_ready    = tx_ready_r;
  assign busy        = busy_r;
  assign overrun     = overrun_r;
  assign underrun    = underrun_r;
  assign frame_abort = abort_r;

endmodule

// File: tb/tb_spi_s_core.sv
// Directed bench for spi_s_core: a cycle-level SPI master model drives the
// pins with 6-clock SCK phases, and each expectation is a hand-computed value.
module tb_spi_s_core;

  localparam int HALF = 6;
  localparam int GAP  = 8;

  logic       clock;
  logic       reset;
  logic [1:0] spi_mode;
  logic       cs_n, sck, mosi;
  logic       miso, miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       busy, overrun, underrun, frame_abort;

  int checks = 0;
  int errors = 0;

  int ovr_cnt = 0;
  int und_cnt = 0;
  int abt_cnt = 0;
  int rx_cnt  = 0;
  logic [7:0] rx_log [0:63];

  logic [7:0] rd, rd2;
  int b_rx, b_ovr, b_und, b_abt;

  spi_s_core #(.SYNC_STAGES(2), .IDLE_TX(8'hFF)) dut (
    .clock(clock), .reset(reset), .spi_mode(spi_mode),
    .cs_n(cs_n), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overrun(overrun), .underrun(underrun), .frame_abort(frame_abort)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observe pulses and RX handshakes at the active edge
  always @(posedge clock) begin
    if (overrun)     ovr_cnt <= ovr_cnt + 1;
    if (underrun)    und_cnt <= und_cnt + 1;
    if (frame_abort) abt_cnt <= abt_cnt + 1;
    if (rx_valid && rx_ready) begin
      rx_log[rx_cnt % 64] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic frame_begin(input logic [1:0] m);
    spi_mode = m;
    sck      = m[1];
    tick(HALF);
    cs_n = 1'b0;
    tick(GAP);
  endtask

  task automatic frame_end();
    tick(HALF);
    cs_n = 1'b1;
    tick(GAP + 2);
  endtask

  // Master side of one byte (or its first nbits), MSB first; returns what it sampled from MISO.
  task automatic xfer(input logic [1:0] m, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!m[0]) begin
        mosi = tx[i];
        tick(HALF);
        r   = {r[6:0], miso};
        sck = ~m[1];
        tick(HALF);
        sck = m[1];
      end else begin
        sck  = ~m[1];
        mosi = tx[i];
        tick(HALF);
        r   = {r[6:0], miso};
        sck = m[1];
        tick(HALF);
      end
    end
    rx = r;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"},     {31'd0, miso},        32'd1);
    check({tag, "_miso_oe"},  {31'd0, miso_oe},     32'd0);
    check({tag, "_rx_data"},  {24'd0, rx_data},     32'd0);
    check({tag, "_rx_valid"}, {31'd0, rx_valid},    32'd0);
    check({tag, "_tx_ready"}, {31'd0, tx_ready},    32'd1);
    check({tag, "_busy"},     {31'd0, busy},        32'd0);
    check({tag, "_overrun"},  {31'd0, overrun},     32'd0);
    check({tag, "_underrun"}, {31'd0, underrun},    32'd0);
    check({tag, "_abort"},    {31'd0, frame_abort}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; spi_mode = 2'd0;
    rx_ready = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    tick(3);
    check_reset_values("rst");
    reset = 1'b0;
    tick(10);

    // Mode 0: master sends 0xC3, slave replies 0x3C
    check("t1_tx_ready", {31'd0, tx_ready}, 32'd1);
    push_tx(8'h3C);
    check("t1_tx_full", {31'd0, tx_ready}, 32'd0);
    b_rx = rx_cnt;
    frame_begin(2'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_miso_oe", {31'd0, miso_oe}, 32'd1);
    check("t1_tx_freed", {31'd0, tx_ready}, 32'd1);
    xfer(2'd0, 8'hC3, 8, rd);
    frame_end();
    check("t1_master_rd", {24'd0, rd}, 32'h3C);
    check("t1_rx_count", rx_cnt - b_rx, 32'd1);
    check("t1_rx_data", {24'd0, rx_log[b_rx % 64]}, 32'hC3);
    check("t1_idle_busy", {31'd0, busy}, 32'd0);

    // Mode 3: master sends 0x00, slave replies 0xA5
    push_tx(8'hA5);
    b_rx = rx_cnt;
    frame_begin(2'd3);
    xfer(2'd3, 8'h00, 8, rd);
    frame_end();
    check("t2_master_rd", {24'd0, rd}, 32'hA5);
    check("t2_rx_count", rx_cnt - b_rx, 32'd1);
    check("t2_rx_data", {24'd0, rx_log[b_rx % 64]}, 32'h00);

    // Mode 1: two bytes under one CS, replies queued back to back
    push_tx(8'h56);
    b_rx = rx_cnt; b_und = und_cnt;
    frame_begin(2'd1);
    check("t3_tx_ready", {31'd0, tx_ready}, 32'd1);
    push_tx(8'h78);
    xfer(2'd1, 8'h12, 8, rd);
    xfer(2'd1, 8'h34, 8, rd2);
    frame_end();
    check("t3_master_rd0", {24'd0, rd}, 32'h56);
    check("t3_master_rd1", {24'd0, rd2}, 32'h78);
    check("t3_rx_count", rx_cnt - b_rx, 32'd2);
    check("t3_rx_data0", {24'd0, rx_log[b_rx % 64]}, 32'h12);
    check("t3_rx_data1", {24'd0, rx_log[(b_rx + 1) % 64]}, 32'h34);
    check("t3_underrun", und_cnt - b_und, 32'd0);

    // Mode 1 with nothing queued: idle byte goes out
    b_rx = rx_cnt; b_und = und_cnt;
    frame_begin(2'd1);
    xfer(2'd1, 8'h66, 8, rd);
    frame_end();
    check("t4_master_rd", {24'd0, rd}, 32'hFF);
    check("t4_underrun", und_cnt - b_und, 32'd1);
    check("t4_rx_data", {24'd0, rx_log[b_rx % 64]}, 32'h66);

    // Consumer stalled across two bytes: first byte kept, second dropped
    rx_ready = 1'b0;
    b_rx = rx_cnt; b_ovr = ovr_cnt;
    frame_begin(2'd0);
    xfer(2'd0, 8'hAA, 8, rd);
    xfer(2'd0, 8'h55, 8, rd);
    frame_end();
    check("t5_rx_valid", {31'd0, rx_valid}, 32'd1);
    check("t5_rx_data", {24'd0, rx_data}, 32'hAA);
    check("t5_overrun", ovr_cnt - b_ovr, 32'd1);
    rx_ready = 1'b1;
    tick(1);
    check("t5_drained", {31'd0, rx_valid}, 32'd0);
    check("t5_rx_count", rx_cnt - b_rx, 32'd1);
    check("t5_rx_logged", {24'd0, rx_log[b_rx % 64]}, 32'hAA);

    // CS rises after 3 bits, then a clean frame
    b_rx = rx_cnt; b_abt = abt_cnt;
    frame_begin(2'd0);
    xfer(2'd0, 8'hE7, 3, rd);
    frame_end();
    check("t6_abort", abt_cnt - b_abt, 32'd1);
    check("t6_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("t6_rx_none", rx_cnt - b_rx, 32'd0);
    frame_begin(2'd0);
    xfer(2'd0, 8'h81, 8, rd);
    frame_end();
    check("t6_rx_count", rx_cnt - b_rx, 32'd1);
    check("t6_rx_data", {24'd0, rx_log[b_rx % 64]}, 32'h81);

    // Reset in the middle of a frame with a reply still held
    push_tx(8'h11);
    b_abt = abt_cnt;
    frame_begin(2'd0);
    push_tx(8'h22);
    check("t7_hold_full", {31'd0, tx_ready}, 32'd0);
    xfer(2'd0, 8'hF0, 4, rd);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check_reset_values("t7");
    xfer(2'd0, 8'h0F, 4, rd);
    check("t7_busy_after", {31'd0, busy}, 32'd0);
    check("t7_oe_after", {31'd0, miso_oe}, 32'd0);
    frame_end();
    check("t7_no_abort", abt_cnt - b_abt, 32'd0);
    b_rx = rx_cnt;
    push_tx(8'h99);
    frame_begin(2'd0);
    xfer(2'd0, 8'h5A, 8, rd);
    frame_end();
    check("t7_master_rd", {24'd0, rd}, 32'h99);
    check("t7_rx_count", rx_cnt - b_rx, 32'd1);
    check("t7_rx_data", {24'd0, rx_log[b_rx % 64]}, 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
